// File: rtl/enemy_pkg.sv
// Shared types and helpers for the enemy squad.
// Latency: none (types and combinational helpers only).
// Backpressure: none.
package enemy_pkg;

    typedef enum logic [1:0] {
        WAIT   = 2'b00,
        CHASE  = 2'b01,
        STUN   = 2'b10,
        SQUASH = 2'b11
    } enemy_state_t;

    // Screen Y grows downward, so DOWN is Y+1 and UP is Y-1.
    typedef enum logic [2:0] {
        NONE,
        UP,
        DOWN,
        LEFT,
        RIGHT
    } move_dir_t;

    localparam int COORD_W = 16;

    function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/enemy_unit.sv
// One enemy: chase/stun/squash/respawn FSM, clamped position, catch compare.
// Latency: state and position update on the frame edge; hit_o is combinational.
// Backpressure: none; every frame is consumed.
module enemy_unit
    import enemy_pkg::*;
#(
    parameter int POS_W         = 10,
    parameter int CNT_W         = 9,
    parameter int STUN_FRAMES   = 120,
    parameter int SQUASH_FRAMES = 60,
    parameter int HIT_RADIUS    = 14,
    parameter int SPAWN_X       = 192,
    parameter int SPAWN_Y       = 36,
    parameter int RELEASE_CNT   = 0,
    parameter int X_MIN         = 0,
    parameter int X_MAX         = 192,
    parameter int Y_MIN         = 5,
    parameter int Y_MAX         = 148
) (
    input  logic             frame_clk,
    input  logic             Reset,
    input  logic             move_en_i,
    input  logic             resync_i,
    input  logic             walk_i,
    input  logic             climb_i,
    input  logic             pepper_i,
    input  logic             crush_i,
    input  logic [POS_W-1:0] chef_x_i,
    input  logic [POS_W-1:0] chef_y_i,
    output logic [POS_W-1:0] x_o,
    output logic [POS_W-1:0] y_o,
    output logic [1:0]       state_o,
    output logic             untouchable_o,
    output logic             squash_o,
    output logic             hit_o
);

    enemy_state_t     state_q, state_d;
    logic [POS_W-1:0] x_q, x_d, y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             squash_q, squash_d;
    move_dir_t        dir;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= WAIT;
            x_q      <= POS_W'(SPAWN_X);
            y_q      <= POS_W'(SPAWN_Y);
            cnt_q    <= CNT_W'(RELEASE_CNT);
            squash_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            cnt_q    <= cnt_d;
            squash_q <= squash_d;
        end
    end

    always_comb begin
        dir = NONE;
        if (climb_i && (y_q < chef_y_i))      dir = DOWN;
        else if (climb_i && (y_q > chef_y_i)) dir = UP;
        else if (walk_i && (x_q > chef_x_i))  dir = LEFT;
        else if (walk_i && (x_q < chef_x_i))  dir = RIGHT;
        else if (!walk_i && !climb_i)         dir = DOWN;
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        cnt_d    = cnt_q;
        squash_d = 1'b0;

        if (resync_i) begin
            state_d = WAIT;
            x_d     = POS_W'(SPAWN_X);
            y_d     = POS_W'(SPAWN_Y);
            cnt_d   = CNT_W'(RELEASE_CNT);
        end else begin
            case (state_q)
                WAIT: begin
                    if (cnt_q == '0) state_d = CHASE;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                CHASE: begin
                    // Crush outranks pepper; neither lets the enemy step this frame.
                    if (crush_i) begin
                        state_d  = SQUASH;
                        cnt_d    = CNT_W'(SQUASH_FRAMES - 1);
                        squash_d = 1'b1;
                    end else if (pepper_i) begin
                        state_d = STUN;
                        cnt_d   = CNT_W'(STUN_FRAMES - 1);
                    end else if (move_en_i) begin
                        case (dir)
                            UP:      if (y_q > POS_W'(Y_MIN)) y_d = y_q - POS_W'(1);
                            DOWN:    if (y_q < POS_W'(Y_MAX)) y_d = y_q + POS_W'(1);
                            LEFT:    if (x_q > POS_W'(X_MIN)) x_d = x_q - POS_W'(1);
                            RIGHT:   if (x_q < POS_W'(X_MAX)) x_d = x_q + POS_W'(1);
                            default: ;
                        endcase
                    end
                end
                STUN: begin
                    if (crush_i) begin
                        state_d  = SQUASH;
                        cnt_d    = CNT_W'(SQUASH_FRAMES - 1);
                        squash_d = 1'b1;
                    end else if (pepper_i) begin
                        cnt_d = CNT_W'(STUN_FRAMES - 1);
                    end else if (cnt_q == '0) begin
                        state_d = CHASE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    // Respawn straight into the chase, without the release stagger.
                    if (cnt_q == '0) begin
                        state_d = CHASE;
                        x_d     = POS_W'(SPAWN_X);
                        y_d     = POS_W'(SPAWN_Y);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        hit_o = 1'b0;
        if ((state_q == CHASE) && !pepper_i && !crush_i &&
            (abs_diff(COORD_W'(x_q), COORD_W'(chef_x_i)) <= COORD_W'(HIT_RADIUS)) &&
            (abs_diff(COORD_W'(y_q), COORD_W'(chef_y_i)) <= COORD_W'(HIT_RADIUS)))
            hit_o = 1'b1;
    end

    assign x_o           = x_q;
    assign y_o           = y_q;
    assign state_o       = state_q;
    assign untouchable_o = (state_q != CHASE);
    assign squash_o      = squash_q;

endmodule

// File: rtl/enemy_squad.sv
// NUM_ENEMIES chasing enemies sharing one move divider and a catch/resync strobe.
// Latency: outputs registered, one frame after inputs; enemy_hurt one frame after the catch.
// Backpressure: none; every frame is consumed.
module enemy_squad
    import enemy_pkg::*;
#(
    parameter int NUM_ENEMIES   = 4,
    parameter int POS_W         = 10,
    parameter int MOVE_DIV      = 2,
    parameter int STUN_FRAMES   = 120,
    parameter int SQUASH_FRAMES = 60,
    parameter int RELEASE_GAP   = 90,
    parameter int HIT_RADIUS    = 14,
    parameter int SPAWN_X0      = 192,
    parameter int SPAWN_DX      = 0,
    parameter int SPAWN_Y       = 36,
    parameter int X_MIN         = 0,
    parameter int X_MAX         = 192,
    parameter int Y_MIN         = 5,
    parameter int Y_MAX         = 148
) (
    input  logic                         frame_clk,
    input  logic                         Reset,
    input  logic [NUM_ENEMIES-1:0]       walk,
    input  logic [NUM_ENEMIES-1:0]       climb,
    input  logic [NUM_ENEMIES-1:0]       pepper_hit,
    input  logic [NUM_ENEMIES-1:0]       crushed,
    input  logic [POS_W-1:0]             ChefX,
    input  logic [POS_W-1:0]             ChefY,
    output logic [NUM_ENEMIES*POS_W-1:0] EnemyX,
    output logic [NUM_ENEMIES*POS_W-1:0] EnemyY,
    output logic [NUM_ENEMIES*2-1:0]     enemy_state,
    output logic [NUM_ENEMIES-1:0]       enemy_untouchable,
    output logic                         enemy_hurt,
    output logic [NUM_ENEMIES-1:0]       squash_event
);

    localparam int REL_MAX = (NUM_ENEMIES - 1) * RELEASE_GAP + 1;
    localparam int TMR_MAX = (STUN_FRAMES > SQUASH_FRAMES) ? STUN_FRAMES : SQUASH_FRAMES;
    localparam int CNT_MAX = (TMR_MAX > REL_MAX) ? TMR_MAX : REL_MAX;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam int DIV_W   = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    logic [DIV_W-1:0]       div_q, div_d;
    logic                   move_en;
    logic                   hurt_q;
    logic [NUM_ENEMIES-1:0] hit;
    logic                   resync;

    assign move_en = (div_q == DIV_W'(MOVE_DIV - 1));
    assign div_d   = move_en ? '0 : div_q + DIV_W'(1);

    // A catch in this frame respawns the whole squad on the same edge that raises enemy_hurt.
    assign resync = |hit;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            div_q  <= '0;
            hurt_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            hurt_q <= resync;
        end
    end

    assign enemy_hurt = hurt_q;

    for (genvar i = 0; i < NUM_ENEMIES; i++) begin : g_enemy
        enemy_unit #(
            .POS_W        (POS_W),
            .CNT_W        (CNT_W),
            .STUN_FRAMES  (STUN_FRAMES),
            .SQUASH_FRAMES(SQUASH_FRAMES),
            .HIT_RADIUS   (HIT_RADIUS),
            .SPAWN_X      (SPAWN_X0 + i * SPAWN_DX),
            .SPAWN_Y      (SPAWN_Y),
            .RELEASE_CNT  (i * RELEASE_GAP),
            .X_MIN        (X_MIN),
            .X_MAX        (X_MAX),
            .Y_MIN        (Y_MIN),
            .Y_MAX        (Y_MAX)
        ) u_enemy (
            .frame_clk    (frame_clk),
            .Reset        (Reset),
            .move_en_i    (move_en),
            .resync_i     (resync),
            .walk_i       (walk[i]),
            .climb_i      (climb[i]),
            .pepper_i     (pepper_hit[i]),
            .crush_i      (crushed[i]),
            .chef_x_i     (ChefX),
            .chef_y_i     (ChefY),
            .x_o          (EnemyX[i*POS_W +: POS_W]),
            .y_o          (EnemyY[i*POS_W +: POS_W]),
            .state_o      (enemy_state[i*2 +: 2]),
            .untouchable_o(enemy_untouchable[i]),
            .squash_o     (squash_event[i]),
            .hit_o        (hit[i])
        );
    end

endmodule

// File: tb/tb_enemy_squad.sv
// Scoreboard bench for enemy_squad: a frame-level reference model queues expected outputs,
// a monitor compares them one step after each frame edge.
`timescale 1ns/1ps
module tb_enemy_squad;

    localparam int N = 4, PW = 10, MOVE_DIV = 2, STUN_F = 120, SQ_F = 60, GAP = 90, HR = 14;
    localparam int SX0 = 192, SDX = 0, SY = 36, XMIN = 0, XMAX = 192, YMIN = 5, YMAX = 148;
    localparam int M_WAIT = 0, M_CHASE = 1, M_STUN = 2, M_SQUASH = 3;

    logic            frame_clk = 1'b0;
    logic            Reset = 1'b1;
    logic [N-1:0]    walk = '0, climb = '0, pepper_hit = '0, crushed = '0;
    logic [PW-1:0]   ChefX = '0, ChefY = '0;
    logic [N*PW-1:0] EnemyX, EnemyY;
    logic [N*2-1:0]  enemy_state;
    logic [N-1:0]    enemy_untouchable, squash_event;
    logic            enemy_hurt;

    typedef struct packed {
        logic [N*PW-1:0] ex;
        logic [N*PW-1:0] ey;
        logic [2*N-1:0]  st;
        logic [N-1:0]    unt;
        logic            hurt;
        logic [N-1:0]    sq;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0, n_fail = 0;

    int m_st[N], m_x[N], m_y[N], m_cnt[N];
    int m_div;
    logic m_hurt;
    logic [N-1:0] m_sq;

    enemy_squad #(
        .NUM_ENEMIES(N), .POS_W(PW), .MOVE_DIV(MOVE_DIV), .STUN_FRAMES(STUN_F),
        .SQUASH_FRAMES(SQ_F), .RELEASE_GAP(GAP), .HIT_RADIUS(HR), .SPAWN_X0(SX0),
        .SPAWN_DX(SDX), .SPAWN_Y(SY), .X_MIN(XMIN), .X_MAX(XMAX), .Y_MIN(YMIN), .Y_MAX(YMAX)
    ) dut (
        .frame_clk(frame_clk), .Reset(Reset), .walk(walk), .climb(climb),
        .pepper_hit(pepper_hit), .crushed(crushed), .ChefX(ChefX), .ChefY(ChefY),
        .EnemyX(EnemyX), .EnemyY(EnemyY), .enemy_state(enemy_state),
        .enemy_untouchable(enemy_untouchable), .enemy_hurt(enemy_hurt),
        .squash_event(squash_event)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic m_spawn_all();
        for (int i = 0; i < N; i++) begin
            m_st[i]  = M_WAIT;
            m_x[i]   = SX0 + i * SDX;
            m_y[i]   = SY;
            m_cnt[i] = i * GAP;
        end
    endtask

    task automatic m_reset();
        m_spawn_all();
        m_div  = 0;
        m_hurt = 1'b0;
        m_sq   = '0;
    endtask

    // One frame of the game rules, applied to plain integer positions and timers.
    task automatic m_step(input logic [N-1:0] w, input logic [N-1:0] cl, input logic [N-1:0] pe,
                          input logic [N-1:0] cr, input int cx, input int cy);
        bit caught = 0;
        bit mv = (m_div == MOVE_DIV - 1);
        m_div = (m_div + 1) % MOVE_DIV;
        for (int i = 0; i < N; i++)
            if (m_st[i] == M_CHASE && !pe[i] && !cr[i] &&
                iabs(m_x[i] - cx) <= HR && iabs(m_y[i] - cy) <= HR)
                caught = 1;
        m_sq   = '0;
        m_hurt = caught;
        if (caught) begin
            m_spawn_all();
            return;
        end
        for (int i = 0; i < N; i++) begin
            int nx = m_x[i], ny = m_y[i];
            if ((m_st[i] == M_CHASE || m_st[i] == M_STUN) && cr[i]) begin
                m_st[i] = M_SQUASH; m_cnt[i] = SQ_F - 1; m_sq[i] = 1'b1;
            end else if (m_st[i] == M_CHASE && pe[i]) begin
                m_st[i] = M_STUN; m_cnt[i] = STUN_F - 1;
            end else if (m_st[i] == M_STUN && pe[i]) begin
                m_cnt[i] = STUN_F - 1;
            end else if (m_st[i] == M_CHASE) begin
                if (mv) begin
                    if (cl[i] && m_y[i] < cy)      ny++;
                    else if (cl[i] && m_y[i] > cy) ny--;
                    else if (w[i] && m_x[i] > cx)  nx--;
                    else if (w[i] && m_x[i] < cx)  nx++;
                    else if (!w[i] && !cl[i])      ny++;
                    if (nx >= XMIN && nx <= XMAX) m_x[i] = nx;
                    if (ny >= YMIN && ny <= YMAX) m_y[i] = ny;
                end
            end else if (m_cnt[i] > 0) begin
                m_cnt[i]--;
            end else begin
                if (m_st[i] == M_SQUASH) begin
                    m_x[i] = SX0 + i * SDX;
                    m_y[i] = SY;
                end
                m_st[i] = M_CHASE;
            end
        end
    endtask

    function automatic exp_t pack_exp();
        exp_t e;
        for (int i = 0; i < N; i++) begin
            e.ex[i*PW +: PW] = PW'(m_x[i]);
            e.ey[i*PW +: PW] = PW'(m_y[i]);
            e.st[i*2 +: 2]   = 2'(m_st[i]);
            e.unt[i]         = (m_st[i] != M_CHASE);
        end
        e.hurt = m_hurt;
        e.sq   = m_sq;
        return e;
    endfunction

    task automatic compare_all(input string tag, input exp_t e);
        check({tag, "_EnemyX"}, 64'(EnemyX), 64'(e.ex));
        check({tag, "_EnemyY"}, 64'(EnemyY), 64'(e.ey));
        check({tag, "_state"}, 64'(enemy_state), 64'(e.st));
        check({tag, "_untouchable"}, 64'(enemy_untouchable), 64'(e.unt));
        check({tag, "_hurt"}, 64'(enemy_hurt), 64'(e.hurt));
        check({tag, "_squash_event"}, 64'(squash_event), 64'(e.sq));
    endtask

    task automatic frame(input logic [N-1:0] w, input logic [N-1:0] cl, input logic [N-1:0] pe,
                         input logic [N-1:0] cr, input int cx, input int cy);
        @(negedge frame_clk);
        walk = w; climb = cl; pepper_hit = pe; crushed = cr;
        ChefX = PW'(cx); ChefY = PW'(cy);
        m_step(w, cl, pe, cr, cx, cy);
        sb.push_back(pack_exp());
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge frame_clk);
        Reset = 1'b1;
        #1;
        m_reset();
        e = pack_exp();
        check("reset_EnemyX_const", 64'(EnemyX), 64'({N{10'd192}}));
        check("reset_EnemyY_const", 64'(EnemyY), 64'({N{10'd36}}));
        check("reset_untouchable_const", 64'(enemy_untouchable), 64'hF);
        compare_all("reset", e);
        @(posedge frame_clk);
        #2;
        Reset = 1'b0;
    endtask

    task automatic frames(input int n, input logic [N-1:0] w, input logic [N-1:0] cl,
                          input int cx, input int cy);
        for (int k = 0; k < n; k++) frame(w, cl, '0, '0, cx, cy);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge frame_clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                compare_all("frame", e);
            end
        end
    end

    initial begin : stimulus
        int cx, cy;
        logic [N-1:0] w, c, p, r;
        do_reset();
        // Staggered release while walking left to X_MIN, then fall to Y_MAX, climb to Y_MIN.
        frames(800, 4'hF, 4'h0, 0, 148);
        frames(300, 4'h0, 4'h0, 100, 0);
        frames(320, 4'h0, 4'hF, 100, 0);
        frames(200, 4'hF, 4'h0, 100, 0);

        // Pepper, re-pepper during stun, ignored hits in WAIT, crush beating pepper.
        do_reset();
        frames(2, 4'hF, 4'h0, 0, 148);
        frame(4'hF, 4'h0, 4'b0001, 4'b0000, 0, 148);
        frame(4'hF, 4'h0, 4'b0100, 4'b1000, 0, 148);
        frames(57, 4'hF, 4'h0, 0, 148);
        frame(4'hF, 4'h0, 4'b0001, 4'b0000, 0, 148);
        frames(40, 4'hF, 4'h0, 0, 148);
        frame(4'hF, 4'h0, 4'b0010, 4'b0010, 0, 148);
        frames(200, 4'hF, 4'h0, 0, 148);

        // Walk into the chef: catch at exactly HIT_RADIUS, then squad resync.
        do_reset();
        frames(120, 4'hF, 4'h0, 150, 36);
        frames(60, 4'hF, 4'h0, 65, 40);

        // Randomised play.
        do_reset();
        cx = 150; cy = 36;
        for (int k = 0; k < 3000; k++) begin
            if (k % 60 == 0) begin
                cx = $urandom_range(100, 200);
                cy = $urandom_range(0, 160);
            end
            w = N'($urandom);
            c = N'($urandom);
            p = '0;
            r = '0;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 39) == 0) p[i] = 1'b1;
                if ($urandom_range(0, 59) == 0) r[i] = 1'b1;
            end
            frame(w, c, p, r, cx, cy);
        end

        @(posedge frame_clk);
        #3;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/enemy_squad.md
Name: enemy_squad

Overview:
- Drives NUM_ENEMIES independent chasing enemies, replacing the single-enemy controller.
- Each enemy has its own chase/stun/squash/respawn state machine, per-enemy terrain flags, boundary clamping and staggered release.
- Sits between the level/terrain lookup, chef controller and burger-drop logic, and feeds the sprite drawer and scoring.
- Coordinates are native screen pixels (no internal ×2 scaling); all logic advances once per frame_clk edge.

Parameters:
NUM_ENEMIES, 4, number of enemy instances
POS_W, 10, coordinate width
MOVE_DIV, 2, enemies step once every MOVE_DIV frames (≥1)
STUN_FRAMES, 120, pepper stun duration in frames
SQUASH_FRAMES, 60, frames between crush and respawn
RELEASE_GAP, 90, stagger between consecutive enemy releases
HIT_RADIUS, 14, catch window half-width, in pixels
SPAWN_X0, 192, spawn X of enemy 0
SPAWN_DX, 0, spawn X increment per enemy index
SPAWN_Y, 36, spawn Y for all enemies
X_MIN, 0; X_MAX, 192; Y_MIN, 5; Y_MAX, 148, inclusive position bounds

Ports:
frame_clk  in  1  frame-rate clock
Reset  in  1  asynchronous active-high reset
walk  in  NUM_ENEMIES  per-enemy: currently on a walkable floor
climb  in  NUM_ENEMIES  per-enemy: currently on a ladder
pepper_hit  in  NUM_ENEMIES  per-enemy pepper hit pulse
crushed  in  NUM_ENEMIES  per-enemy burger-drop crush pulse
ChefX, ChefY  in  POS_W each  chef position
EnemyX, EnemyY  out  NUM_ENEMIES*POS_W each  packed positions; enemy i at [i*POS_W +: POS_W]
enemy_state  out  NUM_ENEMIES*2  packed per-enemy state code
enemy_untouchable  out  NUM_ENEMIES  1 while enemy is in STUN, SQUASH or WAIT
enemy_hurt  out  1  one-frame pulse: chef caught
squash_event  out  NUM_ENEMIES  one-frame pulse on entry to SQUASH, used for scoring

Behaviour:

Reset:
- Reset is asynchronous, active-high, and dominates all other inputs.
- Every enemy enters WAIT at (SPAWN_X0+i*SPAWN_DX, SPAWN_Y).
- Release counter is loaded with i*RELEASE_GAP.
- Move divider is cleared to 0.
- Outputs after reset: enemy_hurt=0, squash_event=0, enemy_untouchable=all 1, enemy_state=all WAIT.

States: WAIT=00, CHASE=01, STUN=10, SQUASH=11.
- WAIT: counter decrements each frame. At 0 the enemy moves to CHASE on the next frame, so release occurs after i*RELEASE_GAP+1 frames.
- CHASE: moves only on frames where the move divider equals MOVE_DIV-1. The divider wraps to 0 and is shared by all enemies. Move priority is first match:
  1. climb && Y<ChefY → Y+1
  2. climb && Y>ChefY → Y−1
  3. walk && X>ChefX → X−1
  4. walk && X<ChefX → X+1
  5. walk or climb set but aligned → hold
  6. neither flag set → Y+1 (fall)
- Each step is committed in the same frame (no one-frame-late motion register).
- Results are clamped to [MIN,MAX]: a step that would cross a bound holds the position instead.
- CHASE + pepper_hit → STUN, counter loaded with STUN_FRAMES−1.
- STUN: position frozen. Counter decrements each frame; at 0 → CHASE. A pepper_hit while in STUN reloads the counter.
- crushed in CHASE or STUN → SQUASH, counter loaded with SQUASH_FRAMES−1, squash_event[i]=1 for that frame.
- SQUASH: position frozen. At counter 0 → CHASE at the spawn position (no stagger).
- crushed or pepper_hit in WAIT or SQUASH is ignored.
- crushed and pepper_hit in the same frame: crush wins.

Catch detection:
- Evaluated on registered positions: |EX−ChefX| ≤ HIT_RADIUS and |EY−ChefY| ≤ HIT_RADIUS.
- Only enemies in CHASE with no crush/pepper this frame qualify.
- Differences are computed unsigned with the larger operand minus the smaller; no wrap.
- Any qualifying enemy → enemy_hurt=1 for the following frame only.
- In that same following frame, all enemies resynchronise to WAIT at spawn with staggered counters, identical to reset.
- enemy_hurt cannot re-assert until some enemy is back in CHASE.

Counters are sized to $clog2 of the largest of STUN_FRAMES, SQUASH_FRAMES and (NUM_ENEMIES−1)*RELEASE_GAP+1.

Decomposition:
- Package enemy_pkg:
  - enemy_state_t enum (WAIT, CHASE, STUN, SQUASH, 2-bit)
  - move_dir_t enum (NONE, UP, DOWN, LEFT, RIGHT)
  - function abs_diff(a,b)
- Sub-module enemy_unit: one enemy's FSM, position registers, clamp and hit compare, exposing a hit flag.
- enemy_squad:
  - generates NUM_ENEMIES enemy_unit instances;
  - owns the move divider;
  - OR-reduces the hit flags into a registered enemy_hurt;
  - broadcasts the resync strobe.

Test Plan:
- Reset (defaults, N=4) → all WAIT, positions (192,36), enemy_untouchable=4'hF. Enemy 0 in CHASE at frame 1, enemy 1 at frame 91, enemy 3 at frame 271.
- Enemy 0 in CHASE, walk=1, climb=0, Chef=(100,36), MOVE_DIV=2 → X decreases by 1 every 2 frames (191, 190, …), Y stays 36. With walk=climb=0 instead → Y increments, stops at 148.
- Chef at (20,36), X_MIN forced to 185 → enemy X stops at 185 and holds; never reads 184 or wraps.
- pepper_hit on enemy 0 → state STUN, frozen for 120 frames. A second pepper at frame 60 extends the stun to frame 180, then CHASE resumes.
- crushed and pepper_hit on enemy 1 in the same frame → SQUASH (not STUN), squash_event[1] pulses once. After 60 frames, CHASE at (192,36).
- Enemy 2 reaches (50,40) with Chef at (60,30) → enemy_hurt high exactly one frame, all enemies WAIT at spawn with stagger reloaded. Chef at (65,40) → no catch.
